clock_monitor: RTL and testbench

- Downstream consumer of the 8-channel clock-measurement block: an Avalon-MM master polls its measurement registers (word addresses 4..11) once per poll period.
- Checks each measurement against a software-programmed nominal ± tolerance window.
- Raises per-channel live alarms, sticky status bits and an interrupt.
- Exposes its own Avalon-MM control slave on the same system interconnect.

---
 rtl/clock_monitor_pkg.sv | 40 ++++
 rtl/clock_monitor_window.sv | 15 +
 rtl/clock_monitor.sv | 198 +++++++++++++++++++
 tb/tb_clock_monitor.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_monitor_pkg.sv
// Shared definitions for the clock monitor: register map, identity constants,
// scan FSM states and the tolerance-window comparison.
package clock_monitor_pkg;

    localparam logic [3:0] ADDR_ID       = 4'd0;
    localparam logic [3:0] ADDR_VERSION  = 4'd1;
    localparam logic [3:0] ADDR_CTRL     = 4'd2;
    localparam logic [3:0] ADDR_STATUS   = 4'd3;
    localparam logic [3:0] ADDR_MASK     = 4'd4;
    localparam logic [3:0] ADDR_NOMINAL  = 4'd5;
    localparam logic [3:0] ADDR_TOL      = 4'd6;
    localparam logic [3:0] ADDR_SCAN_CNT = 4'd7;

    localparam logic [31:0] ID_VALUE      = 32'hc10c_4d0e;
    localparam logic [31:0] VERSION_VALUE = 32'h0001_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_CHECK
    } state_t;

    typedef struct packed {
        logic irq_en;
        logic enable;
    } ctrl_t;

    // 33-bit difference so extreme LAST/NOMINAL pairs never wrap.
    function automatic logic window_fail(input logic [31:0] last,
                                         input logic [31:0] nominal,
                                         input logic [31:0] tol);
        logic [32:0] diff;
        logic [32:0] mag;
        diff = {1'b0, last} - {1'b0, nominal};
        mag  = diff[32] ? (33'd0 - diff) : diff;
        return mag > {1'b0, tol};
    endfunction

endpackage

// File: rtl/clock_monitor_window.sv
// Purpose: flags a measurement outside nominal +/- tolerance.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module clock_monitor_window
    import clock_monitor_pkg::*;
(
    input  logic [31:0] last,
    input  logic [31:0] nominal,
    input  logic [31:0] tol,
    output logic        fail
);

    assign fail = window_fail(last, nominal, tol);

endmodule

// File: rtl/clock_monitor.sv
// Purpose: periodically polls per-channel clock measurements and raises alarms/irq on window violations.
// Latency: control reads return 1 cycle after the strobe; each channel costs 2+READ_LATENCY cycles.
// Backpressure: master holds address/read stable while waitrequest is high; slave never stalls.
module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int          NUM_CH       = 8,
    parameter int          POLL_PERIOD  = 125000000,
    parameter int          READ_LATENCY = 1,
    parameter int          MEAS_BASE    = 4,
    parameter logic [31:0] NOMINAL_RST  = 32'd125000000,
    parameter logic [31:0] TOL_RST      = 32'd1250
)(
    input  logic              csi_clk_clk,
    input  logic              rsi_reset_reset,
    input  logic [3:0]        avs_ctrl_address,
    input  logic              avs_ctrl_read,
    input  logic              avs_ctrl_write,
    output logic [31:0]       avs_ctrl_readdata,
    input  logic [31:0]       avs_ctrl_writedata,
    output logic [3:0]        avm_meas_address,
    output logic              avm_meas_read,
    input  logic              avm_meas_waitrequest,
    input  logic [31:0]       avm_meas_readdata,
    output logic              ins_irq_irq,
    output logic [NUM_CH-1:0] coe_alarm
);

    localparam int TW = $clog2(POLL_PERIOD + 1);
    localparam int LW = $clog2(READ_LATENCY + 1);

    ctrl_t             ctrl;
    logic [NUM_CH-1:0] status;
    logic [NUM_CH-1:0] status_nxt;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] mask_nxt;
    logic [NUM_CH-1:0] alarm;
    logic [NUM_CH-1:0] alarm_nxt;
    logic [31:0]       nominal;
    logic [31:0]       tol;
    logic [31:0]       scan_cnt;
    logic [31:0]       last [8];
    logic [31:0]       rd_mux;
    logic [TW-1:0]     timer;
    logic              start_pend;
    state_t            state;
    logic [2:0]        ch;
    logic [LW-1:0]     lat_cnt;
    logic              fail;
    logic              scan_start;
    logic              timer_wrap;

    assign scan_start = (state == ST_IDLE) && start_pend && ctrl.enable;
    assign timer_wrap = ctrl.enable && (timer == TW'(POLL_PERIOD - 1));

    clock_monitor_window u_window (
        .last    (last[ch]),
        .nominal (nominal),
        .tol     (tol),
        .fail    (fail)
    );

    // A wrap that lands during a scan keeps start_pend set so one more scan follows.
    always_ff @(posedge csi_clk_clk) begin
        if (rsi_reset_reset) begin
            timer      <= '0;
            start_pend <= 1'b0;
        end else begin
            if (!ctrl.enable || timer_wrap)
                timer <= '0;
            else
                timer <= timer + TW'(1);

            if (!ctrl.enable)
                start_pend <= 1'b0;
            else if (timer_wrap)
                start_pend <= 1'b1;
            else if (scan_start)
                start_pend <= 1'b0;
        end
    end

    always_ff @(posedge csi_clk_clk) begin
        if (rsi_reset_reset) begin
            state            <= ST_IDLE;
            ch               <= '0;
            lat_cnt          <= '0;
            avm_meas_read    <= 1'b0;
            avm_meas_address <= '0;
            scan_cnt         <= '0;
            for (int i = 0; i < 8; i++)
                last[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (scan_start) begin
                        ch               <= '0;
                        avm_meas_read    <= 1'b1;
                        avm_meas_address <= 4'(MEAS_BASE);
                        state            <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!avm_meas_waitrequest) begin
                        avm_meas_read <= 1'b0;
                        lat_cnt       <= '0;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == LW'(READ_LATENCY - 1)) begin
                        last[ch] <= avm_meas_readdata;
                        state    <= ST_CHECK;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                ST_CHECK: begin
                    if (ch == 3'(NUM_CH - 1)) begin
                        scan_cnt <= scan_cnt + 32'd1;
                        state    <= ST_IDLE;
                    end else begin
                        ch               <= ch + 3'd1;
                        avm_meas_read    <= 1'b1;
                        avm_meas_address <= 4'(MEAS_BASE) + 4'(ch) + 4'd1;
                        state            <= ST_REQ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A window failure in CHECK wins over a same-cycle write-1-to-clear.
    always_comb begin
        mask_nxt   = mask;
        status_nxt = status;
        alarm_nxt  = alarm;
        if (avs_ctrl_write && avs_ctrl_address == ADDR_MASK)
            mask_nxt = avs_ctrl_writedata[NUM_CH-1:0];
        if (avs_ctrl_write && avs_ctrl_address == ADDR_STATUS)
            status_nxt = status & ~avs_ctrl_writedata[NUM_CH-1:0];
        if (state == ST_CHECK) begin
            alarm_nxt[ch] = fail & mask[ch];
            if (fail && mask[ch])
                status_nxt[ch] = 1'b1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_ctrl_address)
            ADDR_ID:       rd_mux = ID_VALUE;
            ADDR_VERSION:  rd_mux = VERSION_VALUE;
            ADDR_CTRL:     rd_mux = {30'd0, ctrl};
            ADDR_STATUS:   rd_mux = 32'(status);
            ADDR_MASK:     rd_mux = 32'(mask);
            ADDR_NOMINAL:  rd_mux = nominal;
            ADDR_TOL:      rd_mux = tol;
            ADDR_SCAN_CNT: rd_mux = scan_cnt;
            default: begin
                if (int'(avs_ctrl_address[2:0]) < NUM_CH)
                    rd_mux = last[avs_ctrl_address[2:0]];
            end
        endcase
    end

    always_ff @(posedge csi_clk_clk) begin
        if (rsi_reset_reset) begin
            ctrl              <= '0;
            mask              <= '1;
            status            <= '0;
            alarm             <= '0;
            nominal           <= NOMINAL_RST;
            tol               <= TOL_RST;
            ins_irq_irq       <= 1'b0;
            avs_ctrl_readdata <= '0;
        end else begin
            mask        <= mask_nxt;
            status      <= status_nxt;
            alarm       <= alarm_nxt & mask_nxt;
            ins_irq_irq <= ctrl.irq_en & (|status);
            if (avs_ctrl_write) begin
                case (avs_ctrl_address)
                    ADDR_CTRL:    ctrl    <= ctrl_t'(avs_ctrl_writedata[1:0]);
                    ADDR_NOMINAL: nominal <= avs_ctrl_writedata;
                    ADDR_TOL:     tol     <= avs_ctrl_writedata;
                    default: ;
                endcase
            end
            if (avs_ctrl_read)
                avs_ctrl_readdata <= rd_mux;
        end
    end

    assign coe_alarm = alarm;

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor with a latency-1 measurement memory model
// and a programmable waitrequest stall.
module tb_clock_monitor;

    localparam logic [31:0] NOM = 32'd125000000;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic [3:0]  s_addr  = '0;
    logic        s_read  = 1'b0;
    logic        s_write = 1'b0;
    logic [31:0] s_wdata = '0;
    logic [31:0] s_rdata;
    logic [3:0]  m_addr;
    logic        m_read;
    logic        m_wait  = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        irq;
    logic [7:0]  alarm;

    int checks    = 0;
    int failures  = 0;
    int exp_scans = 0;

    logic [31:0] mem [8];
    int acc_cnt [16];
    int acc_total    = 0;
    int stall_cycles = 0;
    int unstable     = 0;
    int read_high    = 0;
    int first4_cyc   = 0;
    int cyc          = 0;
    int cur_stall    = 0;
    logic       stall_en   = 1'b0;
    logic [3:0] stall_addr = '0;
    int         stall_len  = 0;
    logic       r_prev = 1'b0;
    logic       w_prev = 1'b0;
    logic [3:0] a_prev = '0;

    clock_monitor #(
        .NUM_CH       (8),
        .POLL_PERIOD  (100),
        .READ_LATENCY (1),
        .MEAS_BASE    (4),
        .NOMINAL_RST  (32'd125000000),
        .TOL_RST      (32'd1250)
    ) dut (
        .csi_clk_clk          (clk),
        .rsi_reset_reset      (rst),
        .avs_ctrl_address     (s_addr),
        .avs_ctrl_read        (s_read),
        .avs_ctrl_write       (s_write),
        .avs_ctrl_readdata    (s_rdata),
        .avs_ctrl_writedata   (s_wdata),
        .avm_meas_address     (m_addr),
        .avm_meas_read        (m_read),
        .avm_meas_waitrequest (m_wait),
        .avm_meas_readdata    (m_rdata),
        .ins_irq_irq          (irq),
        .coe_alarm            (alarm)
    );

    always #5 clk = ~clk;

    // Slave-side model of the measurement block, evaluated away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (r_prev && !w_prev) begin
            acc_cnt[a_prev] <= acc_cnt[a_prev] + 1;
            acc_total       <= acc_total + 1;
            m_rdata         <= mem[3'(a_prev - 4'd4)];
        end
        if (r_prev && w_prev) begin
            stall_cycles <= stall_cycles + 1;
            if (!m_read || m_addr != a_prev)
                unstable <= unstable + 1;
        end
        if (m_read)
            read_high <= read_high + 1;
        if (m_read && !r_prev && m_addr == 4'd4)
            first4_cyc <= cyc + 1;
        if (stall_en && m_read && m_addr == stall_addr && cur_stall < stall_len) begin
            m_wait    <= 1'b1;
            w_prev    <= 1'b1;
            cur_stall <= cur_stall + 1;
        end else begin
            m_wait <= 1'b0;
            w_prev <= 1'b0;
            if (!m_read)
                cur_stall <= 0;
        end
        r_prev <= m_read;
        a_prev <= m_addr;
    end

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        s_addr  = a;
        s_wdata = d;
        s_write = 1'b1;
        @(negedge clk);
        s_write = 1'b0;
    endtask

    task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        s_addr = a;
        s_read = 1'b1;
        @(negedge clk);
        s_read = 1'b0;
        d = s_rdata;
    endtask

    task automatic wait_total(input int target);
        int n = 0;
        while (acc_total < target && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    task automatic mem_nominal();
        for (int i = 0; i < 8; i++)
            mem[i] = NOM;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] exp_regs [8];
        int rh;
        exp_regs = '{32'hc10c4d0e, 32'h00010000, 32'd0, 32'd0, 32'hFF, NOM, 32'd1250, 32'd0};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (s_rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_readdata: got %h expected %h", s_rdata, 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            csr_read(4'(i), d);
            checks++;
            if (d !== exp_regs[i]) begin
                failures++;
                $display("FAIL reset_reg%0d: got %h expected %h", i, d, exp_regs[i]);
            end
        end
        #1 rh = read_high;
        repeat (500) @(negedge clk);
        #1;
        checks++;
        if (read_high !== rh) begin
            failures++;
            $display("FAIL reset_no_reads: got %0d read cycles expected 0", read_high - rh);
        end
        checks++;
        if (alarm !== 8'h00 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got alarm %h irq %b expected 00 0", alarm, irq);
        end
    endtask

    task automatic test_in_window();
        logic [31:0] d;
        int base_total;
        int c0;
        int base_acc [16];
        for (int i = 0; i < 8; i++)
            mem[i] = NOM + 32'(i * 100);
        base_total = acc_total;
        base_acc   = acc_cnt;
        csr_write(4'd2, 32'd1);
        #1 c0 = cyc;
        wait_total(base_total + 8);
        repeat (3) @(negedge clk);
        csr_write(4'd2, 32'd0);
        exp_scans++;
        checks++;
        if (acc_total !== base_total + 8) begin
            failures++;
            $display("FAIL inwin_reads: got %0d expected %0d", acc_total - base_total, 8);
        end
        checks++;
        if (first4_cyc - c0 !== 101) begin
            failures++;
            $display("FAIL inwin_start_delay: got %0d expected %0d", first4_cyc - c0, 101);
        end
        for (int a = 4; a < 12; a++) begin
            checks++;
            if (acc_cnt[a] - base_acc[a] !== 1) begin
                failures++;
                $display("FAIL inwin_addr%0d_count: got %0d expected 1", a, acc_cnt[a] - base_acc[a]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            csr_read(4'(8 + i), d);
            checks++;
            if (d !== NOM + 32'(i * 100)) begin
                failures++;
                $display("FAIL inwin_last%0d: got %0d expected %0d", i, d, NOM + 32'(i * 100));
            end
        end
        csr_read(4'd3, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL inwin_status: got %h expected %h", d, 32'd0);
        end
        csr_read(4'd7, d);
        checks++;
        if (d !== 32'(exp_scans)) begin
            failures++;
            $display("FAIL inwin_scan_cnt: got %0d expected %0d", d, exp_scans);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] d;
        int base_total;
        mem_nominal();
        mem[2] = 32'd125001250;
        mem[3] = 32'd125001251;
        mem[4] = 32'd124998749;
        base_total = acc_total;
        csr_write(4'd2, 32'd1);
        wait_total(base_total + 8);
        repeat (3) @(negedge clk);
        csr_write(4'd2, 32'd0);
        exp_scans++;
        checks++;
        if (alarm !== 8'h18) begin
            failures++;
            $display("FAIL bound_alarm: got %h expected %h", alarm, 8'h18);
        end
        csr_read(4'd3, d);
        checks++;
        if (d !== 32'h18) begin
            failures++;
            $display("FAIL bound_status: got %h expected %h", d, 32'h18);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL bound_irq_off: got %b expected 0", irq);
        end
        csr_write(4'd2, 32'd2);
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL bound_irq_on: got %b expected 1", irq);
        end
        csr_write(4'd3, 32'h08);
        csr_read(4'd3, d);
        checks++;
        if (d !== 32'h10) begin
            failures++;
            $display("FAIL bound_w1c: got %h expected %h", d, 32'h10);
        end
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL bound_irq_hold: got %b expected 1", irq);
        end
        csr_read(4'd7, d);
        checks++;
        if (d !== 32'(exp_scans)) begin
            failures++;
            $display("FAIL bound_scan_cnt: got %0d expected %0d", d, exp_scans);
        end
    endtask

    task automatic test_waitrequest();
        logic [31:0] d;
        int base_total, base_stall, base_unst;
        int base_acc [16];
        mem_nominal();
        mem[5] = NOM + 32'd55;
        csr_write(4'd3, 32'hFF);
        stall_addr = 4'd9;
        stall_len  = 5;
        stall_en   = 1'b1;
        #1;
        base_total = acc_total;
        base_stall = stall_cycles;
        base_unst  = unstable;
        base_acc   = acc_cnt;
        csr_write(4'd2, 32'd1);
        wait_total(base_total + 8);
        repeat (3) @(negedge clk);
        csr_write(4'd2, 32'd0);
        stall_en = 1'b0;
        exp_scans++;
        checks++;
        if (stall_cycles - base_stall !== 5) begin
            failures++;
            $display("FAIL wait_stall_cycles: got %0d expected 5", stall_cycles - base_stall);
        end
        checks++;
        if (unstable !== base_unst) begin
            failures++;
            $display("FAIL wait_stable: got %0d changes expected 0", unstable - base_unst);
        end
        for (int a = 4; a < 12; a++) begin
            checks++;
            if (acc_cnt[a] - base_acc[a] !== 1) begin
                failures++;
                $display("FAIL wait_addr%0d_count: got %0d expected 1", a, acc_cnt[a] - base_acc[a]);
            end
        end
        csr_read(4'd13, d);
        checks++;
        if (d !== NOM + 32'd55) begin
            failures++;
            $display("FAIL wait_last5: got %0d expected %0d", d, NOM + 32'd55);
        end
        checks++;
        if (alarm !== 8'h00) begin
            failures++;
            $display("FAIL wait_alarm: got %h expected %h", alarm, 8'h00);
        end
    endtask

    task automatic test_set_clear();
        logic [31:0] d;
        int base_total, base7, n;
        mem_nominal();
        mem[3] = 32'd125001251;
        csr_write(4'd3, 32'hFF);
        #1;
        base_total = acc_total;
        base7      = acc_cnt[7];
        csr_write(4'd2, 32'd1);
        n = 0;
        while (acc_cnt[7] == base7 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        // Accept seen; the next negedge lines the write up with ch3's CHECK edge.
        @(negedge clk);
        s_addr  = 4'd3;
        s_wdata = 32'h08;
        s_write = 1'b1;
        @(negedge clk);
        s_write = 1'b0;
        wait_total(base_total + 8);
        repeat (3) @(negedge clk);
        csr_write(4'd2, 32'd0);
        exp_scans++;
        csr_read(4'd3, d);
        checks++;
        if (d !== 32'h08) begin
            failures++;
            $display("FAIL setclr_status: got %h expected %h", d, 32'h08);
        end
        checks++;
        if (alarm !== 8'h08) begin
            failures++;
            $display("FAIL setclr_alarm: got %h expected %h", alarm, 8'h08);
        end
        csr_write(4'd4, 32'hF7);
        checks++;
        if (alarm !== 8'h00) begin
            failures++;
            $display("FAIL setclr_mask_alarm: got %h expected %h", alarm, 8'h00);
        end
        csr_read(4'd3, d);
        checks++;
        if (d !== 32'h08) begin
            failures++;
            $display("FAIL setclr_mask_status: got %h expected %h", d, 32'h08);
        end
        csr_write(4'd4, 32'hFF);
        csr_write(4'd3, 32'hFF);
    endtask

    task automatic test_disable_mid_scan();
        logic [31:0] d;
        int base_total, n;
        mem_nominal();
        #1 base_total = acc_total;
        csr_write(4'd2, 32'd1);
        n = 0;
        while (!(m_read && m_addr == 4'd8) && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        csr_write(4'd2, 32'd0);
        exp_scans++;
        repeat (250) @(negedge clk);
        #1;
        checks++;
        if (acc_total - base_total !== 8) begin
            failures++;
            $display("FAIL dis_reads: got %0d expected 8", acc_total - base_total);
        end
        csr_read(4'd7, d);
        checks++;
        if (d !== 32'(exp_scans)) begin
            failures++;
            $display("FAIL dis_scan_cnt: got %0d expected %0d", d, exp_scans);
        end
    endtask

    task automatic test_reset_mid_req();
        logic [31:0] d;
        logic [31:0] exp_regs [6];
        int base_total, n;
        exp_regs = '{32'd0, 32'd0, 32'hFF, NOM, 32'd1250, 32'd0};
        csr_write(4'd5, 32'd5);
        csr_write(4'd6, 32'd7);
        csr_write(4'd4, 32'h0F);
        stall_addr = 4'd6;
        stall_len  = 5;
        stall_en   = 1'b1;
        csr_write(4'd2, 32'd3);
        n = 0;
        while (!(m_read && m_addr == 4'd6) && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (m_read !== 1'b0 || m_addr !== 4'd0) begin
            failures++;
            $display("FAIL rstreq_master: got read %b addr %h expected 0 0", m_read, m_addr);
        end
        checks++;
        if (s_rdata !== 32'd0 || alarm !== 8'h00 || irq !== 1'b0) begin
            failures++;
            $display("FAIL rstreq_outputs: got rdata %h alarm %h irq %b expected 0 0 0", s_rdata, alarm, irq);
        end
        @(negedge clk);
        rst      = 1'b0;
        stall_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            csr_read(4'(2 + i), d);
            checks++;
            if (d !== exp_regs[i]) begin
                failures++;
                $display("FAIL rstreq_reg%0d: got %h expected %h", 2 + i, d, exp_regs[i]);
            end
        end
        csr_read(4'd8, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL rstreq_last0: got %h expected %h", d, 32'd0);
        end
        #1 base_total = acc_total;
        repeat (150) @(negedge clk);
        #1;
        checks++;
        if (acc_total !== base_total) begin
            failures++;
            $display("FAIL rstreq_no_reads: got %0d expected 0", acc_total - base_total);
        end
    endtask

    initial begin
        mem_nominal();
        test_reset();
        test_in_window();
        test_boundary();
        test_waitrequest();
        test_set_clear();
        test_disable_mid_scan();
        test_reset_mid_req();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
